ca_store: RTL and testbench
===========================

# ca_store

Instruction-cache storage array that answers the cache controller. It holds CACHE_ENTRIES fully associative entries, each with a tag, data and a valid bit. It takes the controller's write strobe, entry address and new-valid flag, and returns a combinational hit plus data for the fetch address. It also keeps a registered valid-entry count and full flag for the controller's fill and clear sequencing.

## Interface
Parameters:
- CACHE_ENTRIES, 8: number of entries; a power of two, at least 2.
- CACHE_ADDR_LEFT, $clog2(CACHE_ENTRIES)-1: MSB of the entry index.
- ADDR_WIDTH, 32: fetch/tag address width.
- DATA_WIDTH, 32: instruction word width.

Ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- rst_  in  1  asynchronous, active-low reset.
- cache_read  in  1  lookup enable.
- cache_write_  in  1  active-low write strobe for entry cache_w_addr.
- cache_w_addr  in  CACHE_ADDR_LEFT+1  entry index to write or clear.
- new_valid  in  1  valid bit written into the entry; 0 means clear.
- pc  in  ADDR_WIDTH  lookup address.
- fill_addr  in  ADDR_WIDTH  tag written when new_valid=1.
- fill_data  in  DATA_WIDTH  data written when new_valid=1.
- cache_hit  out  1  lookup hit (combinational).
- cache_data  out  DATA_WIDTH  data of the hitting entry, else 0.
- cache_full  out  1  registered; all entries valid.
- valid_count  out  $clog2(CACHE_ENTRIES+1)  registered number of valid entries.
- multi_hit  out  1  sticky error flag.

## Operation
- Storage per entry: tag[ADDR_WIDTH], data[DATA_WIDTH], valid.
- Lookup is purely combinational from registered state.
  - match[i] = valid[i] && tag[i]==pc.
  - cache_hit = cache_read && |match.
  - cache_data = data of the lowest-index matching entry when cache_hit=1; otherwise all zeros.
- Write happens on a clock edge with cache_write_=0, at entry w = cache_w_addr.
  - new_valid=1: tag[w]<=fill_addr, data[w]<=fill_data, valid[w]<=1.
  - new_valid=0: valid[w]<=0; tag and data are unchanged.
- Count update, at most one entry per cycle:
  - +1 when a write with new_valid=1 targets an invalid entry.
  - -1 when a write with new_valid=0 targets a valid entry.
  - Otherwise unchanged. This covers overwriting a valid entry, re-clearing an invalid entry, and no write.
- cache_full <= (next valid_count == CACHE_ENTRIES).
- Count range is 0..CACHE_ENTRIES; no overflow or underflow is possible by construction.
- multi_hit is set on any edge where cache_read=1 and two or more entries match. It is cleared only by reset.
- X/illegal handling: cache_w_addr is always in range because CACHE_ENTRIES is a power of two.

## Timing
- Reset (rst_=0, asynchronous assert, synchronous-safe release):
  - All valid, tag and data are cleared to 0.
  - valid_count=0, cache_full=0, multi_hit=0.
  - As a result, cache_hit=0 and cache_data=0.
- Write latency is one cycle. An entry written at edge N is visible to lookup from just after edge N.
- Same-cycle read and write to a matching entry: the lookup reflects the pre-write contents. There is no bypass.
  - Example: clearing a hitting entry still reports cache_hit=1 in that cycle.
- valid_count and cache_full update on the same edge as the write that changes them. They are never combinational from the write inputs.
- Reset asserted mid-fill or mid-clear: everything drops immediately. The write in flight is lost.
- cache_read=0 forces cache_hit=0 and cache_data=0, but stored state is still written normally.

## Test plan
- Reset, then look up pc=0x0 with cache_read=1 -> cache_hit=0, cache_data=0, valid_count=0, cache_full=0, multi_hit=0.
- Write entries 0,1,2 with tags 0x100/0x104/0x108 and data 0xA0/0xA1/0xA2, then look up pc=0x104:
  - required: cache_hit=1, cache_data=0xA1, valid_count=3.
  - pc=0x10C -> cache_hit=0.
- Fill all 8 entries -> valid_count=8 and cache_full=1, both on the 8th write's edge. Then clear entry 5 -> valid_count=7 and cache_full=0 on the next edge; a lookup of entry 5's tag misses.
- Overwrite valid entry 2 with tag 0x200/data 0xB2 -> valid_count unchanged, 0x108 misses, 0x200 hits with 0xB2. Clear an already invalid entry -> count unchanged.
- Same cycle: pc=0x100 lookup while clearing entry 0 -> cache_hit=1, cache_data=0xA0 that cycle; the next cycle misses.
- Write tag 0x300 into entries 3 and 6 with data 0xC3/0xC6, then look up pc=0x300:
  - required: cache_hit=1, cache_data=0xC3, multi_hit=1 from the next edge, staying set until rst_ pulses low.
  - Asserting rst_ mid-sequence clears the count, full flag and all hits.

Source files
------------

// File: rtl/ca_store.sv
// ca_store: fully associative instruction-cache storage with lookup, fill/clear and occupancy tracking
module ca_store #(
    parameter int CACHE_ENTRIES   = 8,
    parameter int CACHE_ADDR_LEFT = $clog2(CACHE_ENTRIES) - 1,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32
) (
    input  logic                               clk,
    input  logic                               rst_,
    input  logic                               cache_read,
    input  logic                               cache_write_,
    input  logic [CACHE_ADDR_LEFT:0]           cache_w_addr,
    input  logic                               new_valid,
    input  logic [ADDR_WIDTH-1:0]              pc,
    input  logic [ADDR_WIDTH-1:0]              fill_addr,
    input  logic [DATA_WIDTH-1:0]              fill_data,
    output logic                               cache_hit,
    output logic [DATA_WIDTH-1:0]              cache_data,
    output logic                               cache_full,
    output logic [$clog2(CACHE_ENTRIES+1)-1:0] valid_count,
    output logic                               multi_hit
);
    localparam int CW = $clog2(CACHE_ENTRIES + 1);

    logic [ADDR_WIDTH-1:0]    r_tag  [CACHE_ENTRIES];
    logic [DATA_WIDTH-1:0]    r_data [CACHE_ENTRIES];
    logic [CACHE_ENTRIES-1:0] r_valid;
    logic [CW-1:0]            r_count;
    logic                     r_full;
    logic                     r_multi;

    logic [CACHE_ENTRIES-1:0] w_match;
    logic                     w_seen;
    logic                     w_multi;
    logic [DATA_WIDTH-1:0]    w_data;
    logic                     w_inc;
    logic                     w_dec;
    logic [CW-1:0]            w_next_count;

    // lowest-index match wins the data mux; a second match flags multi-hit
    always_comb begin
        w_seen  = 1'b0;
        w_multi = 1'b0;
        w_data  = '0;
        for (int i = 0; i < CACHE_ENTRIES; i++) begin
            w_match[i] = r_valid[i] && (r_tag[i] == pc);
            if (w_match[i]) begin
                w_multi = w_multi | w_seen;
                w_data  = w_seen ? w_data : r_data[i];
                w_seen  = 1'b1;
            end
        end
    end

    assign cache_hit  = cache_read && w_seen;
    assign cache_data = cache_hit ? w_data : '0;

    assign w_inc        = !cache_write_ && new_valid && !r_valid[cache_w_addr];
    assign w_dec        = !cache_write_ && !new_valid && r_valid[cache_w_addr];
    assign w_next_count = r_count + CW'(w_inc) - CW'(w_dec);

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            for (int i = 0; i < CACHE_ENTRIES; i++) begin
                r_tag[i]  <= '0;
                r_data[i] <= '0;
            end
            r_valid <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
            r_multi <= 1'b0;
        end else begin
            if (!cache_write_) begin
                r_valid[cache_w_addr] <= new_valid;
                if (new_valid) begin
                    r_tag[cache_w_addr]  <= fill_addr;
                    r_data[cache_w_addr] <= fill_data;
                end
            end
            r_count <= w_next_count;
            r_full  <= (w_next_count == CW'(CACHE_ENTRIES));
            r_multi <= r_multi | (cache_read && w_multi);
        end
    end

    assign valid_count = r_count;
    assign cache_full  = r_full;
    assign multi_hit   = r_multi;
endmodule

// File: tb/tb_ca_store.sv
// tb_ca_store: vector-table and scoreboard bench for ca_store
module tb_ca_store;
    logic        clk = 1'b0;
    logic        rst_ = 1'b0;
    logic        cache_read = 1'b0;
    logic        cache_write_ = 1'b1;
    logic [2:0]  cache_w_addr = '0;
    logic        new_valid = 1'b0;
    logic [31:0] pc = '0;
    logic [31:0] fill_addr = '0;
    logic [31:0] fill_data = '0;
    logic        cache_hit;
    logic [31:0] cache_data;
    logic        cache_full;
    logic [3:0]  valid_count;
    logic        multi_hit;

    int checks = 0;
    int errors = 0;

    ca_store dut (
        .clk(clk), .rst_(rst_), .cache_read(cache_read), .cache_write_(cache_write_),
        .cache_w_addr(cache_w_addr), .new_valid(new_valid), .pc(pc),
        .fill_addr(fill_addr), .fill_data(fill_data), .cache_hit(cache_hit),
        .cache_data(cache_data), .cache_full(cache_full), .valid_count(valid_count),
        .multi_hit(multi_hit)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wn;
        logic [2:0]  wa;
        logic        nv;
        logic [31:0] pc;
        logic [31:0] fa;
        logic [31:0] fd;
        logic        eh;
        logic [31:0] ed;
        logic [3:0]  ec;
        logic        ef;
        logic        em;
    } vec_t;

    vec_t tbl[25];
    vec_t sb[$];

    function automatic vec_t mk(logic rd, logic wn, int wa, logic nv, logic [31:0] vpc,
                                logic [31:0] fa, logic [31:0] fd, logic eh, logic [31:0] ed,
                                int ec, logic ef, logic em);
        vec_t v;
        v.rd = rd; v.wn = wn; v.wa = 3'(wa); v.nv = nv; v.pc = vpc; v.fa = fa; v.fd = fd;
        v.eh = eh; v.ed = ed; v.ec = 4'(ec); v.ef = ef; v.em = em;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic step(input vec_t v, input int idx);
        vec_t e;
        @(negedge clk);
        cache_read = v.rd; cache_write_ = v.wn; cache_w_addr = v.wa; new_valid = v.nv;
        pc = v.pc; fill_addr = v.fa; fill_data = v.fd;
        #1;
        chk($sformatf("v%0d hit", idx), 32'(cache_hit), 32'(v.eh));
        chk($sformatf("v%0d data", idx), cache_data, v.ed);
        sb.push_back(v);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk($sformatf("v%0d count", idx), 32'(valid_count), 32'(e.ec));
        chk($sformatf("v%0d full", idx), 32'(cache_full), 32'(e.ef));
        chk($sformatf("v%0d multi", idx), 32'(multi_hit), 32'(e.em));
    endtask

    initial begin
        //            rd wn wa nv pc       fill_addr fill_data  hit data    cnt full multi
        tbl[0]  = mk(1, 1, 0, 0, 'h0,     'h0,   'h0,   0, 'h0,  0, 0, 0);
        tbl[1]  = mk(1, 0, 0, 1, 'h100,   'h100, 'hA0,  0, 'h0,  1, 0, 0);
        tbl[2]  = mk(0, 0, 1, 1, 'h100,   'h104, 'hA1,  0, 'h0,  2, 0, 0);
        tbl[3]  = mk(1, 0, 2, 1, 'h100,   'h108, 'hA2,  1, 'hA0, 3, 0, 0);
        tbl[4]  = mk(1, 1, 0, 0, 'h104,   'h0,   'h0,   1, 'hA1, 3, 0, 0);
        tbl[5]  = mk(1, 1, 0, 0, 'h10C,   'h0,   'h0,   0, 'h0,  3, 0, 0);
        tbl[6]  = mk(1, 0, 3, 1, 'h10C,   'h10C, 'hA3,  0, 'h0,  4, 0, 0);
        tbl[7]  = mk(1, 0, 4, 1, 'h0,     'h110, 'hA4,  0, 'h0,  5, 0, 0);
        tbl[8]  = mk(1, 0, 5, 1, 'h0,     'h114, 'hA5,  0, 'h0,  6, 0, 0);
        tbl[9]  = mk(1, 0, 6, 1, 'h0,     'h118, 'hA6,  0, 'h0,  7, 0, 0);
        tbl[10] = mk(1, 0, 7, 1, 'h0,     'h11C, 'hA7,  0, 'h0,  8, 1, 0);
        tbl[11] = mk(1, 0, 5, 0, 'h114,   'h0,   'h0,   1, 'hA5, 7, 0, 0);
        tbl[12] = mk(1, 1, 0, 0, 'h114,   'h0,   'h0,   0, 'h0,  7, 0, 0);
        tbl[13] = mk(1, 0, 2, 1, 'h108,   'h200, 'hB2,  1, 'hA2, 7, 0, 0);
        tbl[14] = mk(1, 1, 0, 0, 'h108,   'h0,   'h0,   0, 'h0,  7, 0, 0);
        tbl[15] = mk(1, 1, 0, 0, 'h200,   'h0,   'h0,   1, 'hB2, 7, 0, 0);
        tbl[16] = mk(0, 0, 5, 0, 'h200,   'h0,   'h0,   0, 'h0,  7, 0, 0);
        tbl[17] = mk(1, 0, 0, 0, 'h100,   'h0,   'h0,   1, 'hA0, 6, 0, 0);
        tbl[18] = mk(1, 1, 0, 0, 'h100,   'h0,   'h0,   0, 'h0,  6, 0, 0);
        tbl[19] = mk(1, 0, 3, 1, 'h300,   'h300, 'hC3,  0, 'h0,  6, 0, 0);
        tbl[20] = mk(1, 0, 6, 1, 'h300,   'h300, 'hC6,  1, 'hC3, 6, 0, 0);
        tbl[21] = mk(1, 1, 0, 0, 'h300,   'h0,   'h0,   1, 'hC3, 6, 0, 1);
        tbl[22] = mk(0, 1, 0, 0, 'h0,     'h0,   'h0,   0, 'h0,  6, 0, 1);
        tbl[23] = mk(0, 0, 0, 1, 'h300,   'h100, 'hA0,  0, 'h0,  7, 0, 1);
        tbl[24] = mk(1, 0, 5, 1, 'h300,   'h114, 'hA5,  1, 'hC3, 8, 1, 1);

        repeat (2) @(posedge clk);
        #1;
        chk("reset count", 32'(valid_count), 32'd0);
        chk("reset full", 32'(cache_full), 32'd0);
        chk("reset multi", 32'(multi_hit), 32'd0);
        @(negedge clk);
        rst_ = 1'b1;

        for (int i = 0; i < 25; i++) step(tbl[i], i);

        // reset asserted in the middle of a fill: everything drops, the fill is lost
        @(negedge clk);
        cache_read = 1'b1; cache_write_ = 1'b0; cache_w_addr = 3'd1; new_valid = 1'b1;
        pc = 'h300; fill_addr = 'h500; fill_data = 'hE5;
        #2;
        rst_ = 1'b0;
        #1;
        chk("async count", 32'(valid_count), 32'd0);
        chk("async full", 32'(cache_full), 32'd0);
        chk("async multi", 32'(multi_hit), 32'd0);
        chk("async hit", 32'(cache_hit), 32'd0);
        chk("async data", cache_data, 32'd0);
        @(posedge clk);
        #1;
        chk("held count", 32'(valid_count), 32'd0);
        @(negedge clk);
        rst_ = 1'b1;
        cache_write_ = 1'b1;
        #1;
        chk("post hit 300", 32'(cache_hit), 32'd0);
        pc = 'h500;
        #1;
        chk("lost fill hit", 32'(cache_hit), 32'd0);
        pc = 'h100;
        #1;
        chk("post hit 100", 32'(cache_hit), 32'd0);
        @(posedge clk);
        #1;
        chk("post count", 32'(valid_count), 32'd0);
        chk("post multi", 32'(multi_hit), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
